// File: rtl/irrigacao_pkg.sv
// Shared types and constants for the irrigation controller.
// Holds the FSM state encoding, default timing constants and the level-probe decode.
// Imported by irrigacao_ctrl and tempo_contador.
package irrigacao_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIP  = 2'd1,
        SPRAY = 2'd2
    } irr_state_t;

    localparam int MIN_ON_DEF       = 8;
    localparam int FILL_TIMEOUT_DEF = 64;
    localparam int DISP_PERIOD_DEF  = 16;

    // A probe reporting water above a dry probe below it is physically impossible.
    function automatic logic level_err(input logic nivel_a, input logic nivel_m,
                                       input logic nivel_b);
        return (nivel_a & ~nivel_m) | (nivel_m & ~nivel_b);
    endfunction

endpackage

// File: rtl/tempo_contador.sv
// Saturating up or down cycle counter with clear, load and a terminal flag.
// Latency: count changes on the clock edge after clr/load/en; term is combinational from the count.
// Up mode: term marks the last count before MAXV. Down mode: term marks zero.
module tempo_contador
    import irrigacao_pkg::*;
#(
    parameter int MAXV = 8,
    parameter bit UP   = 1'b1,
    localparam int W   = $clog2(MAXV + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         term
);

    localparam logic [W-1:0] CAP  = W'(MAXV);
    localparam logic [W-1:0] LAST = W'(MAXV - 1);

    logic [W-1:0] cnt;

    // Count register: clear beats load beats count; never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (UP) begin
                if (cnt < CAP) cnt <= cnt + 1'b1;
            end else begin
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
        end
    end

    // Terminal flag seen by the owner in the same cycle as the count.
    always_comb begin
        term = UP ? (cnt >= LAST) : (cnt == '0);
    end

endmodule

// File: rtl/irrigacao_ctrl.sv
// Irrigation controller: valve hysteresis, fill timeout fault, alarm, drip/spray FSM, display select.
// Latency: every output is registered; inputs present before an edge show on outputs at that edge.
// No flow control; sensors are sampled every cycle. Optional macro: DISP_AUTO_EN (auto display paging).
module irrigacao_ctrl
    import irrigacao_pkg::*;
#(
    parameter int MIN_ON       = MIN_ON_DEF,
    parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
    parameter int DISP_PERIOD  = DISP_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic nivel_a,
    input  logic nivel_m,
    input  logic nivel_b,
    input  logic us,
    input  logic ua,
    input  logic t,
    input  logic sl,
    input  logic ack,
    output logic al,
    output logic ve,
    output logic gt,
    output logic asp,
    output logic fill_fault,
    output logic disp_sel
);

    localparam int MW = $clog2(MIN_ON + 1);
    localparam int FW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [MW-1:0] MIN_LOAD = MW'(MIN_ON - 1);

    irr_state_t state, nxt_state;

    logic fill_term, fill_hit, fault_d, al_d, ve_d, disp_d;
    logic want_drip, want_spray, can_drip, can_spray, forced;
    logic min_zero, min_load, min_clr, min_en;

    // Valve-open time: restarts whenever the valve is closed.
    tempo_contador #(.MAXV(FILL_TIMEOUT), .UP(1'b1)) u_fill (
        .clk      (clk),
        .rst      (rst),
        .clr      (~ve),
        .load     (1'b0),
        .load_val ({FW{1'b0}}),
        .en       (ve),
        .term     (fill_term)
    );

    // Minimum on-time of the active irrigation mode, counted down to zero.
    tempo_contador #(.MAXV(MIN_ON), .UP(1'b0)) u_min_on (
        .clk      (clk),
        .rst      (rst),
        .clr      (min_clr),
        .load     (min_load),
        .load_val (MIN_LOAD),
        .en       (min_en),
        .term     (min_zero)
    );

    // Next fault, alarm and valve: a timeout wins over everything, the alarm closes the valve.
    always_comb begin
        fill_hit = ve & fill_term;
        fault_d  = fill_hit | (fill_fault & ~ack);
        al_d     = level_err(nivel_a, nivel_m, nivel_b) | fault_d;
        ve_d     = ~al_d & ~nivel_a & (~nivel_m | ve);
    end

    // Mode selection and min-on counter control; alarm or empty tank always forces IDLE.
    always_comb begin
        want_drip  = us & (t | ~ua);
        want_spray = us & ~t & ua;
        can_drip   = want_drip & nivel_b;
        can_spray  = want_spray & nivel_m;
        forced     = al_d | ~nivel_b;
        nxt_state  = state;
        min_load   = 1'b0;
        min_clr    = 1'b0;
        min_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!al_d && can_drip) begin
                    nxt_state = DRIP;
                    min_load  = 1'b1;
                end else if (!al_d && can_spray) begin
                    nxt_state = SPRAY;
                    min_load  = 1'b1;
                end
            end
            DRIP: begin
                if (forced) begin
                    nxt_state = IDLE;
                    min_clr   = 1'b1;
                end else if (!min_zero) begin
                    min_en = 1'b1;
                end else if (!want_drip) begin
                    if (can_spray) begin
                        nxt_state = SPRAY;
                        min_load  = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                        min_clr   = 1'b1;
                    end
                end
            end
            SPRAY: begin
                if (forced) begin
                    nxt_state = IDLE;
                    min_clr   = 1'b1;
                end else if (!min_zero) begin
                    min_en = 1'b1;
                end else if (!want_spray) begin
                    if (can_drip) begin
                        nxt_state = DRIP;
                        min_load  = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                        min_clr   = 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                min_clr   = 1'b1;
            end
        endcase
    end

    // Irrigation FSM with registered mode outputs; gt and asp come from one state so never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gt    <= 1'b0;
            asp   <= 1'b0;
        end else begin
            state <= nxt_state;
            gt    <= (nxt_state == DRIP);
            asp   <= (nxt_state == SPRAY);
        end
    end

    // Alarm, valve and latched fault registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al         <= 1'b0;
            ve         <= 1'b0;
            fill_fault <= 1'b0;
        end else begin
            al         <= al_d;
            ve         <= ve_d;
            fill_fault <= fault_d;
        end
    end

`ifdef DISP_AUTO_EN
    logic page_term;

    // Page timer: held at zero during an alarm, restarts after each page flip.
    tempo_contador #(.MAXV(DISP_PERIOD), .UP(1'b1)) u_page (
        .clk      (clk),
        .rst      (rst),
        .clr      (al_d | page_term),
        .load     (1'b0),
        .load_val ({$clog2(DISP_PERIOD + 1){1'b0}}),
        .en       (1'b1),
        .term     (page_term)
    );

    // Auto paging; an alarm pins the level page.
    always_comb begin
        disp_d = al_d ? 1'b0 : (disp_sel ^ page_term);
    end
`else
    // Manual paging; an alarm pins the level page.
    always_comb begin
        disp_d = sl & ~al_d;
    end
`endif

    // Display select register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp_sel <= 1'b0;
        else     disp_sel <= disp_d;
    end

endmodule

// File: tb/tb_irrigacao_ctrl.sv
// Self-checking bench for irrigacao_ctrl: directed scenarios plus randomized segments.
// Expected outputs come from a cycle-level behavioural model written from the operating rules.
// Define DISP_AUTO_EN on both bench and RTL to check the auto-paging build.
module tb_irrigacao_ctrl;

    localparam int MIN_ON = 8;
    localparam int FT     = 64;
    localparam int DP     = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic nivel_a = 1'b0, nivel_m = 1'b0, nivel_b = 1'b0;
    logic us = 1'b0, ua = 1'b0, t = 1'b0, sl = 1'b0, ack = 1'b0;
    logic al, ve, gt, asp, fill_fault, disp_sel;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: mode 0 idle / 1 drip / 2 spray, age = cycles since mode entry.
    int m_mode, m_age, m_open, m_page;
    bit m_al, m_ve, m_fault, m_disp;

    irrigacao_ctrl #(.MIN_ON(MIN_ON), .FILL_TIMEOUT(FT), .DISP_PERIOD(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .nivel_a    (nivel_a),
        .nivel_m    (nivel_m),
        .nivel_b    (nivel_b),
        .us         (us),
        .ua         (ua),
        .t          (t),
        .sl         (sl),
        .ack        (ack),
        .al         (al),
        .ve         (ve),
        .gt         (gt),
        .asp        (asp),
        .fill_fault (fill_fault),
        .disp_sel   (disp_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_open = 0; m_page = 0;
        m_al = 0; m_ve = 0; m_fault = 0; m_disp = 0;
    endtask

    // One clock edge of the controller, from the written rules.
    task automatic model_step();
        bit lerr, fault_n, al_n, ve_n, wd, ws, own;
        lerr    = (nivel_a && !nivel_m) || (nivel_m && !nivel_b);
        fault_n = (m_ve && m_open >= FT) || (m_fault && !ack);
        al_n    = lerr || fault_n;
        ve_n    = !al_n && !nivel_a && (!nivel_m || m_ve);
        m_open  = ve_n ? m_open + 1 : 0;
        wd = us && (t || !ua);
        ws = us && !t && ua;
        if (m_mode == 0) begin
            if (!al_n && wd && nivel_b) begin m_mode = 1; m_age = 1; end
            else if (!al_n && ws && nivel_m) begin m_mode = 2; m_age = 1; end
        end else if (al_n || !nivel_b) begin
            m_mode = 0;
        end else if (m_age < MIN_ON) begin
            m_age++;
        end else begin
            own = (m_mode == 1) ? wd : ws;
            if (!own) begin
                if (m_mode == 1 && ws && nivel_m) begin m_mode = 2; m_age = 1; end
                else if (m_mode == 2 && wd && nivel_b) begin m_mode = 1; m_age = 1; end
                else m_mode = 0;
            end
        end
`ifdef DISP_AUTO_EN
        if (al_n) begin
            m_page = 0;
            m_disp = 0;
        end else begin
            m_page++;
            if (m_page == DP) begin m_disp = !m_disp; m_page = 0; end
        end
`else
        m_disp = sl && !al_n;
`endif
        m_al = al_n; m_ve = ve_n; m_fault = fault_n;
    endtask

    task automatic compare_all();
        check("al", al, m_al);
        check("ve", ve, m_ve);
        check("gt", gt, m_mode == 1);
        check("asp", asp, m_mode == 2);
        check("fill_fault", fill_fault, m_fault);
        check("disp_sel", disp_sel, m_disp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // 0 empty, 1 low, 2 medium, 3 full, 4 illegal (high without medium)
    task automatic set_lvl(input int l);
        case (l)
            0: begin nivel_b = 0; nivel_m = 0; nivel_a = 0; end
            1: begin nivel_b = 1; nivel_m = 0; nivel_a = 0; end
            2: begin nivel_b = 1; nivel_m = 1; nivel_a = 0; end
            3: begin nivel_b = 1; nivel_m = 1; nivel_a = 1; end
            default: begin nivel_b = 1; nivel_m = 0; nivel_a = 1; end
        endcase
    endtask

    // Called #1 after an edge: assert reset between edges, hold across one edge.
    task automatic async_reset();
        #3;
        rst = 1;
        #1;
        model_reset();
        check("rst_al", al, 0);
        check("rst_ve", ve, 0);
        check("rst_gt", gt, 0);
        check("rst_asp", asp, 0);
        check("rst_fault", fill_fault, 0);
        check("rst_disp", disp_sel, 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int cnt;
        int lvl;
        int len;
        model_reset();
        set_lvl(3);
        #1 rst = 1;
        #1;
        compare_all();
        @(posedge clk);
        #1 rst = 0;
        cycle();
        cycle();

        // Fill until timeout: valve must stay open exactly FT cycles, then fault and alarm.
        set_lvl(1);
        cnt = 0;
        for (int i = 0; i < FT + 10; i++) begin
            cycle();
            if (ve) cnt++;
        end
        check("fill_len", cnt, FT);
        check("fill_fault_set", fill_fault, 1);
        check("fill_al_set", al, 1);

        // Acknowledge with a full tank.
        set_lvl(3);
        ack = 1;
        cycle();
        ack = 0;
        check("ack_clear", fill_fault, 0);
        cycle();

        // Drip with demand lost after two cycles: min on-time holds it.
        us = 1; t = 1; ua = 0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin cycle(); if (gt) cnt++; end
        us = 0;
        for (int i = 0; i < 10; i++) begin cycle(); if (gt) cnt++; end
        check("drip_len", cnt, MIN_ON);

        // Spray blocked below medium, starts at medium, drops when tank empties.
        us = 1; t = 0; ua = 1;
        set_lvl(1);
        for (int i = 0; i < 3; i++) cycle();
        check("spray_blocked", asp, 0);
        set_lvl(2);
        cycle();
        check("spray_on", asp, 1);
        cycle();
        set_lvl(0);
        cycle();
        check("spray_empty", asp, 0);

        // Illegal probe pattern during drip with the irrigation page selected.
        us = 1; t = 1; sl = 1;
        set_lvl(3);
        for (int i = 0; i < 3; i++) cycle();
        set_lvl(4);
        cycle();
        check("illegal_al", al, 1);
        check("illegal_gt", gt, 0);
        check("illegal_disp", disp_sel, 0);

        // Mid-irrigation asynchronous reset.
        set_lvl(3);
        for (int i = 0; i < 3; i++) cycle();
        async_reset();
        cycle();

        // Display select.
        us = 0;
        sl = 1;
        for (int i = 0; i < 2 * DP + 2; i++) cycle();
        sl = 0;
        cycle();
        sl = 1;
        cycle();

        // Randomized segments: levels held for a while, other inputs random per cycle.
        for (int s = 0; s < 45; s++) begin
            lvl = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
            set_lvl(lvl);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 90))
                                              : int'($urandom_range(1, 25));
            us = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) us = ~us;
                ua  = $urandom_range(0, 1);
                t   = $urandom_range(0, 1);
                if ($urandom_range(0, 5) == 0) sl = ~sl;
                ack = ($urandom_range(0, 7) == 0);
                cycle();
            end
            ack = 0;
            if ($urandom_range(0, 14) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irrigacao_ctrl.md
# irrigacao_ctrl

Sequential controller for the irrigation datapath: it samples the tank-level, soil, air-humidity and temperature sensors each clock and sequences the fill valve, drip and sprinkler outputs. It enforces minimum on-times, a fill timeout with a latched fault, and alarm lockout, and it drives the select line for the level/irrigation 7-segment display mux. It replaces the purely combinational alarm/valve/drip/sprinkler decision path and feeds the existing display decoders and mux unchanged.

## Interface
- MIN_ON, default 8: minimum cycles an irrigation mode stays active once entered (≥1).
- FILL_TIMEOUT, default 64: maximum consecutive cycles with valve open before fill fault (≥1).
- DISP_PERIOD, default 16: cycles per display page in auto mode (≥1).
- clk  in  1  system clock; one clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- nivel_a / nivel_m / nivel_b  in  1 each  water present at high / medium / low probe.
- us  in  1  soil dry (irrigation demand).
- ua  in  1  air humid.
- t  in  1  temperature high.
- sl  in  1  manual display select (0 = level page, 1 = irrigation page).
- ack  in  1  clears latched fill fault.
- al  out  1  alarm.
- ve  out  1  inlet valve open.
- gt  out  1  drip active.
- asp  out  1  sprinkler active.
- fill_fault  out  1  latched fill-timeout fault.
- disp_sel  out  1  display mux select.

## Operation
- level_err = (nivel_a & ~nivel_m) | (nivel_m & ~nivel_b); al = level_err | fill_fault (registered).
- Valve: set when ~nivel_m & ~al; cleared when nivel_a or al. Between medium and high, hold (hysteresis).
- Fill timer: counts cycles with ve=1, cleared when ve=0. Reaching FILL_TIMEOUT sets fill_fault and clears ve on the same edge. fill_fault stays set until an edge with ack=1 clears it.
- Irrigation FSM states: IDLE, DRIP, SPRAY.
- Mode choice: want_drip = us & (t | ~ua); want_spray = us & ~t & ua.
- IDLE→DRIP: want_drip & nivel_b & ~al.
- IDLE→SPRAY: want_spray & nivel_m & ~al. Spray needs at least medium level.
- In DRIP/SPRAY, a down counter is loaded with MIN_ON-1 on entry. While it is nonzero, the state holds regardless of demand.
- At counter 0: demand lost → IDLE; other mode wanted and its level met → switch directly and reload the counter.
- Forced exit to IDLE, overriding the counter: al=1, or ~nivel_b (tank empty).
- gt = (state==DRIP); asp = (state==SPRAY). They are never both 1.

## Timing
- Reset (async): state IDLE; al, ve, gt, asp, fill_fault, disp_sel = 0; all counters 0.
- Conditions present before edge k take effect on outputs at edge k (Moore, registered, 1-cycle latency).
- An asserted rst mid-fill or mid-irrigation drops all outputs immediately, without waiting for a clock.
- Simultaneous al and a mode-entry condition: al wins, so the FSM stays IDLE.
- Simultaneous timeout and valve-close condition at the same edge: fault is set.
- ack while fault is not set: no effect.
- Counter widths: $clog2(PARAM+1); no wrap. Counters saturate or reload as specified.

## Configuration
- DISP_AUTO_EN defined: disp_sel toggles every DISP_PERIOD cycles and sl is ignored. A free-running page counter is cleared by reset.
- DISP_AUTO_EN undefined: disp_sel is sl registered (1-cycle delay), and the page counter is absent.
- In both builds, al=1 forces disp_sel=0 (level page). In auto mode the page counter restarts from 0 when al clears.

## Structure
- Package irrigacao_pkg holds:
  - the state enum (IDLE, DRIP, SPRAY);
  - default parameter constants;
  - the level_err decode as a function.
- One sub-module, tempo_contador: a parameterized down/up counter with load, clear and terminal flag. It is instantiated for min-on, fill timeout and display page.

## Test plan
- Reset with nivel_a=m=b=1 and us=0, then release → all outputs 0. Drop nivel_m → ve=1 at the next edge. Raise nivel_a → ve=0.
- Fill timeout: hold nivel_m=0 for 64 cycles → fill_fault=al=1 and ve=0 at cycle 64. Pulse ack with levels OK → fault clears next edge.
- us=1, t=1, levels full → gt=1 at the next edge. Drop us after 2 cycles → gt stays 1 until 8 cycles total, then 0.
- us=1, t=0, ua=1, nivel_m=0, nivel_b=1 → stays IDLE (spray blocked). Raise nivel_m → asp=1. Clear nivel_b mid-MIN_ON → asp=0 next edge.
- Illegal nivel_a=1, nivel_m=0 while in DRIP → al=1, gt=0, disp_sel=0 at the next edge.
- DISP_AUTO_EN build: no alarm → disp_sel toggles every 16 cycles, sl ignored. Non-auto build: sl change → disp_sel follows one cycle later.
